// File: rtl/tdm_pkg.sv
// Shared TDM link definitions, used by both the transmit and receive ends.
package tdm_pkg;
  localparam int TDM_NCH   = 8;
  localparam int TDM_SEL_W = 3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } tdm_state_e;
endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-NCH slot index counter: clear to 0, realign-load to 1, advance on enable.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int NCH   = TDM_NCH,
  parameter int SEL_W = TDM_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_en,
  output logic [SEL_W-1:0] o_slot,
  output logic             o_last
);

  logic [SEL_W-1:0] r_slot;

  // NCH is a power of two, so the natural wrap of the adder is the modulo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (i_clr) begin
      r_slot <= '0;
    end else if (i_load) begin
      r_slot <= SEL_W'(1);
    end else if (i_en) begin
      r_slot <= r_slot + SEL_W'(1);
    end
  end

  assign o_slot = r_slot;
  assign o_last = (r_slot == SEL_W'(NCH - 1));

endmodule

// File: rtl/tdm_demux_1to8.sv
// 1:8 TDM receiver: fsync alignment, flywheel slot tracking, lock FSM and frame output.
module tdm_demux_1to8
  import tdm_pkg::*;
#(
  parameter int NCH         = TDM_NCH,
  parameter int SEL_W       = TDM_SEL_W,
  parameter int LOCK_FRAMES = 2,
  parameter int LOSS_ERRS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             fsync,
  output logic [NCH-1:0]   dout,
  output logic             dout_valid,
  output logic [SEL_W-1:0] slot,
  output logic             locked,
  output logic             sync_err
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int ERR_W  = $clog2(LOSS_ERRS + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_FRAMES);
  localparam logic [ERR_W-1:0]  ERR_MAX  = ERR_W'(LOSS_ERRS);

  tdm_state_e        r_state;
  tdm_state_e        w_state_next;
  logic [GOOD_W-1:0] r_good, w_good_next, w_good_inc;
  logic [ERR_W-1:0]  r_errs, w_errs_next, w_errs_inc;
  logic [NCH-1:0]    r_shadow;
  logic [NCH-1:0]    r_dout;
  logic              r_dout_valid;
  logic              r_sync_err;

  logic              w_cnt_clr, w_cnt_load, w_cnt_en;
  logic [SEL_W-1:0]  w_slot;
  logic              w_last;
  logic              w_slot0;
  logic              w_shadow_we;
  logic [SEL_W-1:0]  w_wr_idx;
  logic              w_sync_err_next;
  logic              w_deliver;

  tdm_slot_counter #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_slot_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_cnt_clr),
    .i_load (w_cnt_load),
    .i_en   (w_cnt_en),
    .o_slot (w_slot),
    .o_last (w_last)
  );

  assign w_slot0    = (w_slot == '0);
  assign w_good_inc = (r_good == GOOD_MAX) ? r_good : r_good + GOOD_W'(1);
  assign w_errs_inc = (r_errs == ERR_MAX) ? r_errs : r_errs + ERR_W'(1);
  // A realigning beat is slot 0 regardless of where the counter currently points.
  assign w_wr_idx   = w_cnt_load ? '0 : w_slot;
  // Frame completes on the last-slot beat even if this same beat drops lock.
  assign w_deliver  = din_valid && (r_state == LOCKED) && w_last;

  always_comb begin
    w_state_next    = r_state;
    w_good_next     = r_good;
    w_errs_next     = r_errs;
    w_cnt_clr       = 1'b0;
    w_cnt_load      = 1'b0;
    w_cnt_en        = 1'b0;
    w_shadow_we     = 1'b0;
    w_sync_err_next = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (fsync) begin
            w_state_next = CHECK;
            w_good_next  = '0;
            w_cnt_load   = 1'b1;
            w_shadow_we  = 1'b1;
          end
        end
        CHECK: begin
          w_shadow_we = 1'b1;
          w_cnt_en    = 1'b1;
          if (w_slot0 && fsync) begin
            w_good_next = w_good_inc;
            if (w_good_inc >= GOOD_MAX) begin
              w_state_next = LOCKED;
            end
          end else if (w_slot0) begin
            w_sync_err_next = 1'b1;
            w_state_next    = HUNT;
            w_good_next     = '0;
            w_cnt_clr       = 1'b1;
          end else if (fsync) begin
            w_sync_err_next = 1'b1;
            w_good_next     = '0;
            w_cnt_load      = 1'b1;
          end
        end
        LOCKED: begin
          w_shadow_we = 1'b1;
          w_cnt_en    = 1'b1;
          if (w_slot0 != fsync) begin
            w_sync_err_next = 1'b1;
            if (w_errs_inc >= ERR_MAX) begin
              w_state_next = HUNT;
              w_errs_next  = '0;
              w_good_next  = '0;
              w_cnt_clr    = 1'b1;
            end else begin
              w_errs_next = w_errs_inc;
            end
          end else if (w_slot0) begin
            w_errs_next = '0;
          end
        end
        default: begin
          w_state_next = HUNT;
          w_cnt_clr    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_good       <= '0;
      r_errs       <= '0;
      r_shadow     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_good       <= w_good_next;
      r_errs       <= w_errs_next;
      r_dout_valid <= w_deliver;
      r_sync_err   <= w_sync_err_next;
      if (w_shadow_we) begin
        r_shadow[w_wr_idx] <= din;
      end
      if (w_deliver) begin
        r_dout <= {din, r_shadow[NCH-2:0]};
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign slot       = w_slot;
  assign locked     = (r_state == LOCKED);
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Directed and random-frame bench for the 1:8 TDM receiver.
module tb_tdm_demux_1to8;

  logic       clk;
  logic       rst_n;
  logic       din_valid;
  logic       din;
  logic       fsync;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  int n_total = 0;
  int n_bad   = 0;
  int dv_cnt  = 0;
  int err_cnt = 0;
  logic       sb_on = 1'b0;
  logic [7:0] sb[$];

  tdm_demux_1to8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .fsync      (fsync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      dv_cnt++;
      if (sb_on) begin
        if (sb.size() == 0) begin
          check_val("t6_unexpected_frame", {24'd0, dout}, 32'hFFFF_FFFF);
        end else begin
          check_val("t6_dout", {24'd0, dout}, {24'd0, sb.pop_front()});
        end
      end
    end
    if (sync_err === 1'b1) err_cnt++;
  end

  task automatic beat(input logic v, input logic d, input logic f);
    din_valid = v;
    din       = d;
    fsync     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic fs0);
    for (int k = 0; k < 8; k++) beat(1'b1, b[k], (k == 0) ? fs0 : 1'b0);
    din_valid = 1'b0;
    $display("frame %02h sent fsync0=%0d locked=%0d", b, fs0, locked);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0;
    logic [2:0] s_hold;
    logic [7:0] b;
    rst_n = 1'b0; din_valid = 1'b0; din = 1'b0; fsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_dout", {24'd0, dout}, 32'h0);
    check_val("rst_dout_valid", {31'd0, dout_valid}, 32'h0);
    check_val("rst_slot", {29'd0, slot}, 32'h0);
    check_val("rst_locked", {31'd0, locked}, 32'h0);
    check_val("rst_sync_err", {31'd0, sync_err}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // T1: lock acquisition over three frames
    d0 = dv_cnt;
    send_frame(8'hA5, 1'b1);
    check_val("t1_locked_f1", {31'd0, locked}, 32'h0);
    send_frame(8'h3C, 1'b1);
    beat(1'b0, 1'b0, 1'b0);
    check_val("t1_locked_f2", {31'd0, locked}, 32'h0);
    check_val("t1_no_dv", dv_cnt - d0, 32'd0);
    beat(1'b1, 1'b1, 1'b1);
    check_val("t1_locked_slot0_f3", {31'd0, locked}, 32'h1);
    for (int k = 1; k < 8; k++) beat(1'b1, 1'b1, 1'b0);
    check_val("t1_dv", {31'd0, dout_valid}, 32'h1);
    check_val("t1_dout", {24'd0, dout}, 32'hFF);
    beat(1'b0, 1'b0, 1'b0);
    check_val("t1_dv_pulse", {31'd0, dout_valid}, 32'h0);
    check_val("t1_dv_count", dv_cnt - d0, 32'd1);

    // T2: din_valid toggling inside a frame
    d0 = dv_cnt;
    b = 8'h81;
    for (int k = 0; k < 8; k++) begin
      beat(1'b1, b[k], (k == 0) ? 1'b1 : 1'b0);
      s_hold = slot;
      beat(1'b0, ~b[k], 1'b1);
      check_val("t2_slot_hold", {29'd0, slot}, {29'd0, s_hold});
    end
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    check_val("t2_dv_count", dv_cnt - d0, 32'd1);
    check_val("t2_dout", {24'd0, dout}, 32'h81);
    check_val("t2_locked", {31'd0, locked}, 32'h1);

    // T3: single missed fsync tolerated, two consecutive drop lock
    e0 = err_cnt;
    send_frame(8'h5A, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    check_val("t3_err_one", err_cnt - e0, 32'd1);
    check_val("t3_still_locked", {31'd0, locked}, 32'h1);
    check_val("t3_dout", {24'd0, dout}, 32'h5A);
    send_frame(8'h33, 1'b1);
    check_val("t3_dout_good", {24'd0, dout}, 32'h33);
    e0 = err_cnt;
    send_frame(8'h11, 1'b0);
    check_val("t3_dout_miss1", {24'd0, dout}, 32'h11);
    check_val("t3_locked_miss1", {31'd0, locked}, 32'h1);
    send_frame(8'h22, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    check_val("t3_err_two", err_cnt - e0, 32'd2);
    check_val("t3_unlocked", {31'd0, locked}, 32'h0);
    check_val("t3_dout_hold", {24'd0, dout}, 32'h11);

    // T4: early fsync while in CHECK realigns
    d0 = dv_cnt;
    beat(1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 4; k++) beat(1'b1, 1'b0, 1'b0);
    check_val("t4_slot_pre", {29'd0, slot}, 32'd4);
    beat(1'b1, 1'b0, 1'b1);
    check_val("t4_sync_err", {31'd0, sync_err}, 32'h1);
    check_val("t4_slot_realign", {29'd0, slot}, 32'd1);
    check_val("t4_locked", {31'd0, locked}, 32'h0);
    for (int k = 1; k < 8; k++) beat(1'b1, 1'b0, 1'b0);
    send_frame(8'h6E, 1'b1);
    check_val("t4_locked_after1", {31'd0, locked}, 32'h0);
    send_frame(8'hC3, 1'b1);
    beat(1'b0, 1'b0, 1'b0);
    check_val("t4_locked_after2", {31'd0, locked}, 32'h1);
    check_val("t4_dout", {24'd0, dout}, 32'hC3);
    check_val("t4_dv_count", dv_cnt - d0, 32'd1);

    // T5: asynchronous reset mid-frame while locked
    b = 8'h5F;
    for (int k = 0; k < 5; k++) beat(1'b1, b[k], (k == 0) ? 1'b1 : 1'b0);
    din_valid = 1'b0;
    check_val("t5_slot_pre", {29'd0, slot}, 32'd5);
    #1 rst_n = 1'b0;
    #1;
    check_val("t5_dout", {24'd0, dout}, 32'h0);
    check_val("t5_slot", {29'd0, slot}, 32'h0);
    check_val("t5_locked", {31'd0, locked}, 32'h0);
    check_val("t5_dv", {31'd0, dout_valid}, 32'h0);
    check_val("t5_sync_err", {31'd0, sync_err}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = dv_cnt;
    send_frame(8'h0F, 1'b1);
    send_frame(8'hF0, 1'b1);
    beat(1'b0, 1'b0, 1'b0);
    check_val("t5_no_dv", dv_cnt - d0, 32'd0);
    send_frame(8'h99, 1'b1);
    beat(1'b0, 1'b0, 1'b0);
    check_val("t5_relock", {31'd0, locked}, 32'h1);
    check_val("t5_dout", {24'd0, dout}, 32'h99);

    // T6: random frames with random idle gaps
    d0 = dv_cnt;
    e0 = err_cnt;
    sb_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      b = 8'($urandom);
      sb.push_back(b);
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 2)) beat(1'b0, 1'($urandom), 1'($urandom));
        beat(1'b1, b[k], (k == 0) ? 1'b1 : 1'b0);
      end
    end
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    sb_on = 1'b0;
    check_val("t6_dv_count", dv_cnt - d0, 32'd1000);
    check_val("t6_sync_err", err_cnt - e0, 32'd0);
    check_val("t6_sb_left", sb.size(), 32'd0);
    $display("t6 random frames done, %0d delivered", dv_cnt - d0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
